// File: rtl/mpu_pkg.sv
// mpu_pkg: shared definitions for the MPU table configuration sequencer.
// Holds the command opcodes, the word offsets of the fields inside one
// table entry, the acl bit positions, the sequencer state encoding and a
// helper that packs the acl bits into their table word.
package mpu_pkg;

  // Command opcodes carried on cmd_op.
  localparam logic [1:0] MPU_OP_WR      = 2'b00;
  localparam logic [1:0] MPU_OP_INV     = 2'b01;
  localparam logic [1:0] MPU_OP_INV_ALL = 2'b10;
  localparam logic [1:0] MPU_OP_RSVD    = 2'b11;

  // Word offset k (1..5) of each field inside an entry.
  localparam logic [2:0] MPU_W_CODE_S = 3'd1;
  localparam logic [2:0] MPU_W_CODE_E = 3'd2;
  localparam logic [2:0] MPU_W_DATA_S = 3'd3;
  localparam logic [2:0] MPU_W_DATA_E = 3'd4;
  localparam logic [2:0] MPU_W_ACL    = 3'd5;

  // Bit positions of the permissions inside the acl word.
  localparam int MPU_ACL_R = 2;
  localparam int MPU_ACL_W = 1;
  localparam int MPU_ACL_X = 0;

  // Sequencer states, kept as plain constants for legacy tooling.
  typedef logic [2:0] mpu_state_t;
  localparam mpu_state_t ST_IDLE  = 3'd0;
  localparam mpu_state_t ST_CHECK = 3'd1;
  localparam mpu_state_t ST_WRITE = 3'd2;
  localparam mpu_state_t ST_NEXT  = 3'd3;
  localparam mpu_state_t ST_DONE  = 3'd4;

  // Packs {r,w,x} into the zero-extended acl table word.
  function automatic logic [31:0] acl_word(input logic [2:0] rwx);
    logic [31:0] w;
    w            = '0;
    w[MPU_ACL_R] = rwx[2];
    w[MPU_ACL_W] = rwx[1];
    w[MPU_ACL_X] = rwx[0];
    return w;
  endfunction

endpackage

// File: rtl/mpu_cfg_order.sv
// mpu_cfg_order: combinational write-order table.
// Maps (op, step) to the entry word offset written at that step and
// whether the written data is forced to zero.
// Ports:
//   op        in  2  latched command opcode
//   step      in  3  write step 0..4 within the current entry
//   word_off  out 3  word offset k (1..5) for this step
//   zero_data out 1  1 when the step writes 0 (invalidate)
module mpu_cfg_order
  import mpu_pkg::*;
(
  input  logic [1:0] op,
  input  logic [2:0] step,
  output logic [2:0] word_off,
  output logic       zero_data
);

  // Write: acl first, code_end last so the entry only becomes live once
  // everything else is in place. Invalidate: the code range goes first so
  // the entry is dead before its other fields are touched.
  always_comb begin
    word_off  = MPU_W_ACL;
    zero_data = 1'b0;
    if (op == MPU_OP_WR) begin
      case (step)
        3'd0:    word_off = MPU_W_ACL;
        3'd1:    word_off = MPU_W_DATA_S;
        3'd2:    word_off = MPU_W_DATA_E;
        3'd3:    word_off = MPU_W_CODE_S;
        default: word_off = MPU_W_CODE_E;
      endcase
    end else begin
      zero_data = 1'b1;
      case (step)
        3'd0:    word_off = MPU_W_CODE_E;
        3'd1:    word_off = MPU_W_CODE_S;
        3'd2:    word_off = MPU_W_DATA_S;
        3'd3:    word_off = MPU_W_DATA_E;
        default: word_off = MPU_W_ACL;
      endcase
    end
  end

endmodule

// File: rtl/mpu_cfg_seq.sv
// mpu_cfg_seq: turns one entry-level command into the ordered word writes
// that program the memory-resident MPU table, then pulses resync so the
// MPU reloads its cached copy.
// Optional feature macro: MPU_CFG_CHECK_EN -- when defined, write commands
// whose code or data range has start > end are rejected in CHECK.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op, cmd_idx, cmd_acl    opcode, entry index, {r,w,x}
//   cmd_code_start/end,
//   cmd_data_start/end          range bounds written into the entry
//   mem_req/mem_gnt             memory write request / grant
//   mem_addr, mem_wdata,
//   mem_wstrb                   word address, data, byte strobes
//   busy                        high whenever not idle
//   done, err, resync           completion, reject and cache-refill pulses
module mpu_cfg_seq
  import mpu_pkg::*;
#(
  parameter int MPU_START_ADDR = 768,
  parameter int MPU_ITEM_NUM   = 16,
  parameter int MPU_ITEM_LEN   = 5,  // fixed at 5, other values unsupported
  parameter int IDX_W          = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_idx,
  input  logic [2:0]       cmd_acl,
  input  logic [31:0]      cmd_code_start,
  input  logic [31:0]      cmd_code_end,
  input  logic [31:0]      cmd_data_start,
  input  logic [31:0]      cmd_data_end,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic [21:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             resync
);

  localparam logic [21:0]    BASE     = 22'(MPU_START_ADDR);
  localparam logic [IDX_W:0] NUM_EXT  = (IDX_W+1)'(MPU_ITEM_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MPU_ITEM_NUM - 1);

  mpu_state_t       state;
  logic [1:0]       op_q;
  logic [IDX_W-1:0] idx_q;
  logic [2:0]       acl_q;
  logic [31:0]      cs_q, ce_q, ds_q, de_q;
  logic [2:0]       step;
  logic             reject;

  logic [2:0]       word_off;
  logic             zero_data;
  logic [31:0]      word_data;
  logic             bad;

  mpu_cfg_order u_order (
    .op        (op_q),
    .step      (step),
    .word_off  (word_off),
    .zero_data (zero_data)
  );

  // The index is widened by one bit so the range test stays meaningful
  // even when the table fills the whole index space.
  always_comb begin
    bad = 1'b0;
    if (op_q == MPU_OP_RSVD)
      bad = 1'b1;
    else if ((op_q == MPU_OP_WR || op_q == MPU_OP_INV) && ({1'b0, idx_q} >= NUM_EXT))
      bad = 1'b1;
`ifdef MPU_CFG_CHECK_EN
    if (op_q == MPU_OP_WR && (cs_q > ce_q || ds_q > de_q))
      bad = 1'b1;
`else
`endif
  end

  always_comb begin
    word_data = '0;
    case (word_off)
      MPU_W_CODE_S: word_data = cs_q;
      MPU_W_CODE_E: word_data = ce_q;
      MPU_W_DATA_S: word_data = ds_q;
      MPU_W_DATA_E: word_data = de_q;
      MPU_W_ACL:    word_data = acl_word(acl_q);
      default:      word_data = '0;
    endcase
  end

  // Invalidate-all reuses the single-entry path: the index starts at 0
  // and NEXT steps it until the last entry has been cleared.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      op_q   <= MPU_OP_WR;
      idx_q  <= '0;
      acl_q  <= '0;
      cs_q   <= '0;
      ce_q   <= '0;
      ds_q   <= '0;
      de_q   <= '0;
      step   <= '0;
      reject <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            idx_q <= (cmd_op == MPU_OP_INV_ALL) ? '0 : cmd_idx;
            acl_q <= cmd_acl;
            cs_q  <= cmd_code_start;
            ce_q  <= cmd_code_end;
            ds_q  <= cmd_data_start;
            de_q  <= cmd_data_end;
            step  <= '0;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          reject <= bad;
          state  <= bad ? ST_DONE : ST_WRITE;
        end
        ST_WRITE: begin
          if (mem_gnt) begin
            if (step == 3'd4) begin
              step <= '0;
              if (op_q == MPU_OP_INV_ALL && idx_q != LAST_IDX)
                state <= ST_NEXT;
              else
                state <= ST_DONE;
            end else begin
              step <= step + 3'd1;
            end
          end
        end
        ST_NEXT: begin
          idx_q <= idx_q + IDX_W'(1);
          step  <= '0;
          state <= ST_WRITE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign mem_req   = (state == ST_WRITE);
  assign mem_wstrb = mem_req ? 4'b1111 : 4'b0000;
  assign mem_addr  = mem_req ? BASE + 22'(idx_q) * 22'(MPU_ITEM_LEN) + 22'(word_off) : BASE;
  assign mem_wdata = (mem_req && !zero_data) ? word_data : '0;
  assign done      = (state == ST_DONE);
  assign err       = done && reject;
  assign resync    = done && !reject;

endmodule

// File: tb/tb_mpu_cfg_seq.sv
// tb_mpu_cfg_seq: self-checking bench for mpu_cfg_seq.
// A table of directed commands plus a batch of random commands is run
// against a reference model that derives the expected write list, reject
// flag and completion cycle straight from the table layout rules.
// A second instance with a 12-entry table exercises the index range check.
// Honors MPU_CFG_CHECK_EN in its reference model.
module tb_mpu_cfg_seq;

  localparam int START = 768;
  localparam int ITEMS = 16;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  idx;
    logic [31:0] cs, ce, ds, de;
    logic [2:0]  acl;
  } cmd_t;

  typedef struct {
    cmd_t cmd;
    int   gnt_mode;   // 0 tied high, 1 three stall cycles per word, 2 random
    int   exp_done;   // completion cycle, -1 = derive from model + stalls
    bit   exp_err;
    int   poke;       // cycle to pulse cmd_valid while busy, 0 = none
    bit   from_table;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_valid_b = 1'b0;
  logic        cmd_ready, cmd_ready_b;
  logic [1:0]  cmd_op = '0;
  logic [3:0]  cmd_idx = '0;
  logic [2:0]  cmd_acl = '0;
  logic [31:0] cmd_code_start = '0, cmd_code_end = '0, cmd_data_start = '0, cmd_data_end = '0;
  logic        mem_req, mem_req_b;
  logic        mem_gnt = 1'b0;
  logic        mem_gnt_b = 1'b1;
  logic [21:0] mem_addr, mem_addr_b;
  logic [31:0] mem_wdata, mem_wdata_b;
  logic [3:0]  mem_wstrb, mem_wstrb_b;
  logic        busy, done, err, resync;
  logic        busy_b, done_b, err_b, resync_b;

  int checks = 0;
  int passes = 0;

  int gnt_mode = 0;
  int stall_cnt = 0;
  int stalls = 0;
  int strb_err = 0, stable_err = 0, withdraw_err = 0;
  bit pend = 0;
  logic [21:0] prev_addr;
  logic [31:0] prev_data;
  logic [21:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic [21:0] exp_addr[$];
  logic [31:0] exp_data[$];

  always #5 clk = ~clk;

  mpu_cfg_seq dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
    .cmd_acl(cmd_acl), .cmd_code_start(cmd_code_start), .cmd_code_end(cmd_code_end),
    .cmd_data_start(cmd_data_start), .cmd_data_end(cmd_data_end),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .busy(busy), .done(done), .err(err), .resync(resync)
  );

  mpu_cfg_seq #(.MPU_START_ADDR(768), .MPU_ITEM_NUM(12), .MPU_ITEM_LEN(5), .IDX_W(4)) dut_b (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
    .cmd_acl(cmd_acl), .cmd_code_start(cmd_code_start), .cmd_code_end(cmd_code_end),
    .cmd_data_start(cmd_data_start), .cmd_data_end(cmd_data_end),
    .mem_req(mem_req_b), .mem_gnt(mem_gnt_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_wstrb(mem_wstrb_b), .busy(busy_b), .done(done_b), .err(err_b), .resync(resync_b)
  );

  // Memory-side responder and monitor: decides the grant for the coming
  // edge, records accepted writes and watches request stability/strobes.
  always @(negedge clk) begin
    if (!busy) stall_cnt = 0;
    if (gnt_mode == 0) mem_gnt = 1'b1;
    else if (gnt_mode == 1) begin
      if (mem_req && stall_cnt == 3) begin mem_gnt = 1'b1; stall_cnt = 0; end
      else if (mem_req) begin mem_gnt = 1'b0; stall_cnt++; end
      else mem_gnt = 1'b0;
    end else mem_gnt = ($urandom_range(0, 2) != 0);

    if (mem_req) begin
      if (mem_wstrb !== 4'hF) strb_err++;
      if (pend && (mem_addr !== prev_addr || mem_wdata !== prev_data)) stable_err++;
      if (mem_gnt) begin
        cap_addr.push_back(mem_addr);
        cap_data.push_back(mem_wdata);
        pend = 0;
      end else begin
        stalls++;
        pend = 1;
        prev_addr = mem_addr;
        prev_data = mem_wdata;
      end
    end else begin
      if (mem_wstrb !== 4'h0) strb_err++;
      if (pend && resetn) withdraw_err++;
      pend = 0;
    end
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic report_fail(input string name);
    checks++;
    $display("[TB] FAIL %s: timed out waiting on the DUT", name);
  endtask

  function automatic logic [31:0] field_of(input cmd_t c, input int k);
    case (k)
      1: return c.cs;
      2: return c.ce;
      3: return c.ds;
      4: return c.de;
      default: return {29'b0, c.acl};
    endcase
  endfunction

  // Reference model: expected write list, reject flag and NEXT count.
  task automatic build_model(input cmd_t c, output int nnext, output bit rej);
    int order_wr[5]  = '{5, 3, 4, 1, 2};
    int order_inv[5] = '{2, 1, 3, 4, 5};
    int first, last, k;
    exp_addr.delete();
    exp_data.delete();
    rej = (c.op == 2'b11) || (c.op != 2'b10 && int'(c.idx) >= ITEMS);
`ifdef MPU_CFG_CHECK_EN
    if (c.op == 2'b00 && (c.cs > c.ce || c.ds > c.de)) rej = 1;
`endif
    nnext = 0;
    if (!rej) begin
      first = (c.op == 2'b10) ? 0 : int'(c.idx);
      last  = (c.op == 2'b10) ? ITEMS - 1 : int'(c.idx);
      nnext = last - first;
      for (int e = first; e <= last; e++)
        for (int j = 0; j < 5; j++) begin
          k = (c.op == 2'b00) ? order_wr[j] : order_inv[j];
          exp_addr.push_back(22'(START + e * 5 + k));
          exp_data.push_back((c.op == 2'b00) ? field_of(c, k) : 32'h0);
        end
    end
  endtask

  task automatic wait_ready(input string name);
    int w = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && w < 500) begin @(negedge clk); w++; end
    if (w >= 500) report_fail(name);
  endtask

  task automatic drive_cmd(input cmd_t c);
    cmd_op = c.op; cmd_idx = c.idx; cmd_acl = c.acl;
    cmd_code_start = c.cs; cmd_code_end = c.ce;
    cmd_data_start = c.ds; cmd_data_end = c.de;
  endtask

  task automatic scramble_cmd();
    cmd_op = 2'($urandom); cmd_idx = 4'($urandom); cmd_acl = 3'($urandom);
    cmd_code_start = $urandom; cmd_code_end = $urandom;
    cmd_data_start = $urandom; cmd_data_end = $urandom;
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag);
    int  nnext, n, expd;
    bit  rej, got;
    bit  exp_e;
    build_model(v.cmd, nnext, rej);
    exp_e    = v.from_table ? v.exp_err : rej;
    gnt_mode = v.gnt_mode;
    wait_ready({tag, "_ready"});
    cap_addr.delete(); cap_data.delete(); stalls = 0;
    drive_cmd(v.cmd);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    scramble_cmd();
    n = 0; got = 0;
    while (!got && n < 1000) begin
      @(negedge clk);
      n++;
      if (v.poke != 0 && n == v.poke) begin
        check_output({tag, "_ready_busy"}, cmd_ready, 0);
        cmd_valid = 1'b1;
      end else if (v.poke != 0 && n == v.poke + 1) cmd_valid = 1'b0;
      if (done === 1'b1) got = 1;
    end
    if (!got) begin report_fail({tag, "_done"}); return; end
    expd = (v.exp_done >= 0) ? v.exp_done : 2 + exp_addr.size() + nnext + stalls;
    check_output({tag, "_done_cycle"}, n, expd);
    check_output({tag, "_err"}, err, exp_e);
    check_output({tag, "_resync"}, resync, !exp_e);
    @(negedge clk);
    check_output({tag, "_ready_after"}, {cmd_ready, busy, done}, 3'b100);
    check_output({tag, "_nwrites"}, cap_addr.size(), exp_addr.size());
    for (int i = 0; i < cap_addr.size() && i < exp_addr.size(); i++)
      check_output($sformatf("%s_write%0d", tag, i), {cap_addr[i], cap_data[i]}, {exp_addr[i], exp_data[i]});
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] idx,
                              input logic [31:0] cs, input logic [31:0] ce,
                              input logic [31:0] ds, input logic [31:0] de,
                              input logic [2:0] acl, input int gm, input int ed,
                              input bit ee, input int poke);
    vec_t v;
    v.cmd.op = op; v.cmd.idx = idx; v.cmd.cs = cs; v.cmd.ce = ce;
    v.cmd.ds = ds; v.cmd.de = de; v.cmd.acl = acl;
    v.gnt_mode = gm; v.exp_done = ed; v.exp_err = ee; v.poke = poke; v.from_table = 1;
    return v;
  endfunction

  task automatic run_b(input logic [3:0] idx, input int exp_done, input bit exp_err,
                       input int exp_reqs, input logic [21:0] exp_first);
    int n = 0, reqs = 0;
    bit got = 0;
    logic [21:0] first = 22'd0;
    cmd_t c;
    c.op = 2'b00; c.idx = idx; c.cs = 32'h10; c.ce = 32'h20; c.ds = 32'h30; c.de = 32'h40; c.acl = 3'b101;
    @(negedge clk);
    drive_cmd(c);
    cmd_valid_b = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_b = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (mem_req_b) begin
        if (reqs == 0) first = mem_addr_b;
        reqs++;
      end
      if (done_b === 1'b1) got = 1;
    end
    if (!got) begin report_fail("b_done"); return; end
    check_output($sformatf("b%0d_done_cycle", idx), n, exp_done);
    check_output($sformatf("b%0d_err_resync", idx), {err_b, resync_b}, {exp_err, !exp_err});
    check_output($sformatf("b%0d_reqs", idx), reqs, exp_reqs);
    check_output($sformatf("b%0d_first_addr", idx), first, exp_first);
  endtask

  // Reset lands during the third write of a write-entry command.
  task automatic reset_mid_command();
    cmd_t c;
    int   extra = 0;
    c.op = 2'b00; c.idx = 4'd7; c.cs = 32'h1000; c.ce = 32'h1FFF; c.ds = 32'h2000; c.de = 32'h2FFF; c.acl = 3'b011;
    gnt_mode = 0;
    wait_ready("rst_ready");
    drive_cmd(c);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_output("rst_third_write", {mem_req, mem_addr}, {1'b1, 22'(START + 7 * 5 + 4)});
    resetn = 1'b0;
    @(negedge clk);
    check_output("rst_state", {mem_req, busy, cmd_ready, done, resync}, 5'b00100);
    check_output("rst_addr_data", {mem_addr, mem_wdata}, {22'(START), 32'h0});
    resetn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done || resync) extra++;
    end
    check_output("rst_no_done", extra, 0);
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    // Directed table: write entry 3, invalidate entry 15, invalidate all
    // with a command poked mid-run, stalled write, reserved op, swapped range.
    tbl[0] = mk(2'b00, 4'd3, 32'h100, 32'h1FF, 32'h300, 32'h33F, 3'b110, 0, 7, 0, 0);
    tbl[1] = mk(2'b01, 4'd15, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 7, 0, 0);
    tbl[2] = mk(2'b10, 4'd9, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 97, 0, 40);
    tbl[3] = mk(2'b00, 4'd2, 32'hA000, 32'hAFFF, 32'hB000, 32'hB0FF, 3'b101, 1, 22, 0, 0);
    tbl[4] = mk(2'b11, 4'd5, 32'h1, 32'h2, 32'h3, 32'h4, 3'b111, 0, 2, 1, 0);
`ifdef MPU_CFG_CHECK_EN
    tbl[5] = mk(2'b00, 4'd9, 32'h200, 32'h100, 32'h400, 32'h500, 3'b100, 0, 2, 1, 0);
`else
    tbl[5] = mk(2'b00, 4'd9, 32'h200, 32'h100, 32'h400, 32'h500, 3'b100, 0, 7, 0, 0);
`endif

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_ctrl", {cmd_ready, mem_req, busy, done, err, resync}, 6'b100000);
    check_output("reset_mem", {mem_wstrb, mem_addr, mem_wdata}, {4'h0, 22'd768, 32'h0});
    check_output("reset_b_ready", cmd_ready_b, 1'b1);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) apply_stimulus(tbl[i], $sformatf("vec%0d", i));

    reset_mid_command();
    apply_stimulus(tbl[0], "after_reset");

    run_b(4'd12, 2, 1, 0, 22'd0);
    run_b(4'd11, 7, 0, 5, 22'd828);

    for (int i = 0; i < 24; i++) begin
      int sel;
      sel = $urandom_range(0, 11);
      rv.cmd.op  = (sel < 6) ? 2'b00 : (sel < 9) ? 2'b01 : (sel < 10) ? 2'b11 : 2'b10;
      rv.cmd.idx = 4'($urandom);
      rv.cmd.cs  = $urandom; rv.cmd.ce = $urandom;
      rv.cmd.ds  = $urandom; rv.cmd.de = $urandom;
      rv.cmd.acl = 3'($urandom);
      rv.gnt_mode = $urandom_range(0, 2);
      rv.exp_done = -1; rv.exp_err = 0; rv.poke = 0; rv.from_table = 0;
      apply_stimulus(rv, $sformatf("rnd%0d", i));
    end

    check_output("strobe_rule", strb_err, 0);
    check_output("req_stable", stable_err, 0);
    check_output("req_never_withdrawn", withdraw_err, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
